// File: rtl/perceptron_host_pkg.sv
// Shared types and byte constants for the perceptron host: command FSM states,
// opcodes, response bytes and the UART receiver states.
`timescale 1ns/1ps
package perceptron_host_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_WRITE,
        OP_READ,
        OP_LED
    } op_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] OPC_WRITE = 8'h57;
    localparam logic [7:0] OPC_READ  = 8'h52;
    localparam logic [7:0] OPC_LED   = 8'h4C;
    localparam logic [7:0] RESP_ACK  = 8'h4B;
    localparam logic [7:0] RESP_ERR  = 8'h00;

endpackage

// File: rtl/uart_phy.sv
// UART physical layer: input synchroniser, 8N1 receiver with framing check and
// an independent 8N1 transmitter sharing one bit-period length.
`timescale 1ns/1ps
module uart_phy
    import perceptron_host_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       i_rx,
    output logic       o_tx,
    input  logic       i_txLoad,
    input  logic [7:0] i_txData,
    output logic       o_txBusy,
    output logic       o_rxValid,
    output logic [7:0] o_rxData,
    output logic       o_rxFrameErr
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    r_sync;
    logic          r_rxPrev;
    logic          w_rx;
    rx_state_t     r_rxState, w_rxStateNext;
    logic [CW-1:0] r_rxCnt, w_rxCntNext;
    logic [2:0]    r_rxBit, w_rxBitNext;
    logic [7:0]    r_rxShift, w_rxShiftNext;

    logic          r_tx;
    logic          r_txBusy;
    logic [8:0]    r_txShift;
    logic [3:0]    r_txBit;
    logic [CW-1:0] r_txCnt;

    assign w_rx         = r_sync[1];
    assign o_rxData     = r_rxShift;
    assign o_tx         = r_tx;
    assign o_txBusy     = r_txBusy;

    // Synchroniser resets to idle-high so release never looks like a start edge
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_sync    <= 2'b11;
            r_rxPrev  <= 1'b1;
            r_rxState <= RX_IDLE;
            r_rxCnt   <= '0;
            r_rxBit   <= '0;
            r_rxShift <= '0;
        end else begin
            r_sync    <= {r_sync[0], i_rx};
            r_rxPrev  <= w_rx;
            r_rxState <= w_rxStateNext;
            r_rxCnt   <= w_rxCntNext;
            r_rxBit   <= w_rxBitNext;
            r_rxShift <= w_rxShiftNext;
        end
    end

    always_comb begin
        w_rxStateNext = r_rxState;
        w_rxCntNext   = r_rxCnt + 1'b1;
        w_rxBitNext   = r_rxBit;
        w_rxShiftNext = r_rxShift;
        o_rxValid     = 1'b0;
        o_rxFrameErr  = 1'b0;
        case (r_rxState)
            RX_IDLE: begin
                w_rxCntNext = '0;
                if (r_rxPrev && !w_rx) w_rxStateNext = RX_START;
            end
            RX_START: begin
                if (r_rxCnt == HALF_LAST) begin
                    w_rxCntNext   = '0;
                    w_rxBitNext   = '0;
                    w_rxStateNext = w_rx ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_rxCnt == BIT_LAST) begin
                    w_rxCntNext   = '0;
                    w_rxShiftNext = {w_rx, r_rxShift[7:1]};
                    w_rxBitNext   = r_rxBit + 3'd1;
                    if (r_rxBit == 3'd7) w_rxStateNext = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_rxCnt == BIT_LAST) begin
                    w_rxCntNext   = '0;
                    w_rxStateNext = RX_IDLE;
                    o_rxValid     = w_rx;
                    o_rxFrameErr  = !w_rx;
                end
            end
            default: w_rxStateNext = RX_IDLE;
        endcase
    end

    // Shift register holds data plus stop bit; the start bit is driven on load
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_tx      <= 1'b1;
            r_txBusy  <= 1'b0;
            r_txShift <= '1;
            r_txBit   <= '0;
            r_txCnt   <= '0;
        end else if (!r_txBusy) begin
            if (i_txLoad) begin
                r_txBusy  <= 1'b1;
                r_tx      <= 1'b0;
                r_txShift <= {1'b1, i_txData};
                r_txBit   <= '0;
                r_txCnt   <= '0;
            end
        end else if (r_txCnt != BIT_LAST) begin
            r_txCnt <= r_txCnt + 1'b1;
        end else begin
            r_txCnt <= '0;
            if (r_txBit == 4'd9) begin
                r_txBusy <= 1'b0;
                r_tx     <= 1'b1;
            end else begin
                r_tx      <= r_txShift[0];
                r_txShift <= {1'b1, r_txShift[8:1]};
                r_txBit   <= r_txBit + 4'd1;
            end
        end
    end

endmodule

// File: rtl/perceptron_host.sv
// Host command front end: UART byte commands write/read an 8-bit register file
// and an LED register, each answered with a single response byte.
`timescale 1ns/1ps
module perceptron_host
    import perceptron_host_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int BAUD         = 115200,
    parameter int N_REG        = 16,
    parameter int LED_W        = 8,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               host_tx,
    output logic               uart_tx,
    output logic [LED_W-1:0]   leds,
    output logic [8*N_REG-1:0] reg_q,
    output logic               cmd_err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TO_LIMIT     = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW           = $clog2(TO_LIMIT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_LIMIT - 1);

    logic                  w_rxValid, w_rxFrameErr, w_txBusy, w_txLoad;
    logic [7:0]            w_rxData, w_rdData;
    state_t                r_state, w_stateNext;
    op_t                   r_op, w_opNext;
    logic [7:0]            r_addr, w_addrNext, r_resp, w_respNext;
    logic                  r_addrHit, w_addrHitNext, w_rxHit;
    logic                  w_err, w_regWe, w_ledWe, w_timeout, w_waiting;
    logic [N_REG-1:0][7:0] r_regs;
    logic [LED_W-1:0]      r_leds;
    logic                  r_cmdErr;
    logic [TW-1:0]         r_toCnt;

    uart_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
        .clk          (clk),
        .nRst         (nRst),
        .i_rx         (host_tx),
        .o_tx         (uart_tx),
        .i_txLoad     (w_txLoad),
        .i_txData     (r_resp),
        .o_txBusy     (w_txBusy),
        .o_rxValid    (w_rxValid),
        .o_rxData     (w_rxData),
        .o_rxFrameErr (w_rxFrameErr)
    );

    assign reg_q     = r_regs;
    assign leds      = r_leds;
    assign cmd_err   = r_cmdErr;
    assign w_rxHit   = {1'b0, w_rxData} < 9'(N_REG);
    assign w_waiting = (r_state == ST_ADDR) || (r_state == ST_DATA);
    // A byte arriving on the expiry cycle wins over the timeout
    assign w_timeout = w_waiting && !w_rxValid && (r_toCnt == TO_LAST);

    always_comb begin
        w_rdData = RESP_ERR;
        for (int i = 0; i < N_REG; i++) begin
            if (w_rxData == 8'(i)) w_rdData = r_regs[i];
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_opNext      = r_op;
        w_addrNext    = r_addr;
        w_addrHitNext = r_addrHit;
        w_respNext    = r_resp;
        w_err         = w_rxFrameErr;
        w_regWe       = 1'b0;
        w_ledWe       = 1'b0;
        w_txLoad      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rxValid) begin
                    case (w_rxData)
                        OPC_WRITE: begin w_opNext = OP_WRITE; w_stateNext = ST_ADDR; end
                        OPC_READ:  begin w_opNext = OP_READ;  w_stateNext = ST_ADDR; end
                        OPC_LED:   begin w_opNext = OP_LED;   w_stateNext = ST_DATA; end
                        default:   w_err = 1'b1;
                    endcase
                end
            end
            ST_ADDR: begin
                if (w_rxValid) begin
                    w_addrNext    = w_rxData;
                    w_addrHitNext = w_rxHit;
                    w_err         = !w_rxHit;
                    w_respNext    = w_rxHit ? w_rdData : RESP_ERR;
                    w_stateNext   = (r_op == OP_READ) ? ST_RESP : ST_DATA;
                end else if (w_timeout) begin
                    w_err       = 1'b1;
                    w_stateNext = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (w_rxValid) begin
                    w_regWe     = (r_op == OP_WRITE) && r_addrHit;
                    w_ledWe     = (r_op == OP_LED);
                    w_respNext  = RESP_ACK;
                    w_stateNext = ST_RESP;
                end else if (w_timeout) begin
                    w_err       = 1'b1;
                    w_stateNext = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (w_rxValid) w_err = 1'b1;
                if (!w_txBusy) begin
                    w_txLoad    = 1'b1;
                    w_stateNext = ST_IDLE;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
        if (w_rxFrameErr && w_waiting) w_stateNext = ST_IDLE;
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_WRITE;
            r_addr    <= '0;
            r_addrHit <= 1'b0;
            r_resp    <= '0;
            r_regs    <= '0;
            r_leds    <= '0;
            r_cmdErr  <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_op      <= w_opNext;
            r_addr    <= w_addrNext;
            r_addrHit <= w_addrHitNext;
            r_resp    <= w_respNext;
            r_cmdErr  <= w_err;
            if (w_ledWe) r_leds <= w_rxData[LED_W-1:0];
            if (w_regWe) begin
                for (int i = 0; i < N_REG; i++) begin
                    if (r_addr == 8'(i)) r_regs[i] <= w_rxData;
                end
            end
        end
    end

    // Inter-byte timer only runs while a command is partially received
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_toCnt <= '0;
        end else if (w_rxValid || !w_waiting) begin
            r_toCnt <= '0;
        end else begin
            r_toCnt <= r_toCnt + 1'b1;
        end
    end

endmodule

// File: doc/perceptron_host.md
PERCEPTRON_HOST -- requirements
Module: perceptron_host

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD, integer-truncated (434 at defaults).
REQ-003 Parameter N_REG, default 16, number of 8-bit host-writable registers (1..256).
REQ-004 Parameter LED_W, default 8, LED output width (1..8).
REQ-005 Parameter TIMEOUT_BITS, default 20, inter-byte timeout in bit periods.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 nRst  input  1  reset, asynchronous assert, active-low.
REQ-008 host_tx  input  1  serial line from host, idle high, asynchronous to clk.
REQ-009 uart_tx  output  1  serial line to host, idle high.
REQ-010 leds  output  LED_W  LED register.
REQ-011 reg_q  output  8*N_REG  register file, flat; register i occupies bits [8i+7:8i].
REQ-012 cmd_err  output  1  one-cycle pulse on any protocol or framing error.

Function
REQ-013 host_tx shall pass through a 2-flop synchroniser before any use.
REQ-014 RX: a high-to-low transition while idle starts a frame; start bit resampled at CLKS_PER_BIT/2; if high, abort silently to idle.
REQ-015 RX: 8 data bits, LSB first, sampled at bit centres; stop bit sampled at its centre; if low, byte discarded and cmd_err pulsed.
REQ-016 RX: a valid byte produces a one-cycle rx_valid strobe to the command FSM, at the stop-bit centre sample.
REQ-017 TX: frame = 1 start (0), 8 data LSB first, 1 stop (1), each exactly CLKS_PER_BIT cycles; tx_busy high from load until stop bit end.
REQ-018 Command FSM states: IDLE, ADDR, DATA, RESP.
REQ-019 IDLE: byte 0x57 ('W') -> ADDR (write); 0x52 ('R') -> ADDR (read); 0x4C ('L') -> DATA (LED); any other byte -> cmd_err pulse, stay IDLE.
REQ-020 ADDR: byte latched as address; write -> DATA; read -> RESP with response = reg[addr].
REQ-021 DATA: write -> reg[addr] <= byte, response 0x4B ('K'), -> RESP; LED -> leds <= byte[LED_W-1:0], response 0x4B, -> RESP.
REQ-022 Address >= N_REG: write ignored, read response 0x00; cmd_err pulsed in both cases; response still sent.
REQ-023 RESP: response byte loaded into TX on the first cycle tx_busy is low, then -> IDLE; register/LED update visible on reg_q/leds the cycle after the final command byte strobe.
REQ-024 A byte received while in RESP shall be dropped with cmd_err pulse.
REQ-025 Timeout: in ADDR or DATA, if TIMEOUT_BITS*CLKS_PER_BIT cycles elapse with no rx_valid, -> IDLE, cmd_err pulse, no register change, no response; counter restarts on each rx_valid.
REQ-026 Framing error in ADDR or DATA -> IDLE, no register change, no response.
REQ-027 Simultaneous timeout expiry and rx_valid: rx_valid wins, no error.
REQ-028 RX and TX operate concurrently and independently; a new command may begin while the previous response is still transmitting.

Reset
REQ-029 nRst low shall asynchronously force: FSM IDLE, RX/TX idle, uart_tx=1, leds=0, reg_q=0, cmd_err=0, all counters 0.
REQ-030 Reset mid-frame shall abandon both frames; the first start edge after release begins a fresh frame.

Structure
REQ-031 Package perceptron_host_pkg shall hold the FSM state enum, opcode constants (0x57, 0x52, 0x4C), ACK 0x4B and the error/read-miss value 0x00.
REQ-032 One sub-module, uart_phy (synchroniser, RX deserialiser, TX serialiser, parameter CLKS_PER_BIT); command FSM, register file and timeout counter reside in perceptron_host.

Verification (CLK_HZ=1000000, BAUD=100000 -> 10 clocks/bit, N_REG=4, LED_W=8)
REQ-033 Send 0x57,0x02,0xA5 -> reg_q[23:16]=0xA5; uart_tx returns 0x4B; cmd_err never pulses.
REQ-034 After REQ-033, send 0x52,0x02 -> uart_tx returns 0xA5; send 0x52,0x07 -> returns 0x00 with one cmd_err pulse.
REQ-035 Send 0x4C,0x3C -> leds=0x3C, ack 0x4B; send 0x11 -> one cmd_err pulse, no TX activity.
REQ-036 Send 0x57,0x01, then idle 200 clocks -> cmd_err pulse at 200 clocks after the 0x01 strobe; then 0x52,0x01 -> returns 0x00.
REQ-037 Send a frame with stop bit 0 -> byte dropped, cmd_err pulse; a 5-clock low glitch on idle line -> no byte, no error.
REQ-038 Assert nRst mid-way through the 0xA5 data byte of a write -> all outputs reset values, uart_tx=1; a subsequent full write succeeds normally.
